// File: rtl/rmii_rx_frame_ctrl_pkg.sv
// Shared types and constants for the RMII receive frame controller.
// Also holds the byte-wise CRC-32 update used when RMII_RX_FRAME_CTRL_CRC_CHECK_EN is defined.
package rmii_rx_frame_ctrl_pkg;

    localparam int LEN_W = 11;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } state_e;

    // Reflected CRC-32, one byte per call, LSB of the data byte first.
    function automatic logic [31:0] crc32_update(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/rmii_rx_sat_counter.sv
// Statistics counter that saturates at all-ones; clear wins over increment.
module rmii_rx_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/rmii_rx_frame_ctrl.sv
// Dibit-to-byte frame controller behind the RMII MAC receiver, with length/alignment checks and stats.
// Optional FCS check is compiled in with RMII_RX_FRAME_CTRL_CRC_CHECK_EN.
module rmii_rx_frame_ctrl
    import rmii_rx_frame_ctrl_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             arstn,
    input  logic             enable,
    input  logic             cnt_clr,
    input  logic             s_axi_tvalid,
    input  logic             s_axi_tlast,
    input  logic [1:0]       s_axi_tdata,
    input  logic             s_axi_tuser,
    output logic             s_axi_tready,
    output logic             m_axi_tvalid,
    output logic             m_axi_tlast,
    output logic [7:0]       m_axi_tdata,
    output logic             m_axi_tuser,
    input  logic             m_axi_tready,
    output logic             busy,
    output logic [CNT_W-1:0] frame_ok_cnt,
    output logic [CNT_W-1:0] frame_err_cnt,
    output logic [CNT_W-1:0] frame_drop_cnt
);

    // A beat transfers on a clock edge where valid && ready are both high; the master
    // side keeps its payload stable while valid && !ready, and the slave side never stalls.
    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       byte_q, byte_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, drop_q, drop_d, term_q, term_d, s_tready_q;
    logic             out_valid_q, out_valid_d, out_last_q, out_last_d, out_user_q, out_user_d;
    logic [7:0]       out_data_q, out_data_d;

    logic             s_beat, out_free, frame_beat, drop_inc, ok_inc, err_inc;
    logic             load, load_last, load_user;
    logic [7:0]       load_data, asm_byte;
    logic [1:0]       cur_idx;
    logic [LEN_W-1:0] cur_cnt, cnt_nx;
    logic             cur_ovf, byte_done, at_max, end_err, crc_err;

    assign s_beat   = s_axi_tvalid & s_tready_q;
    assign out_free = ~out_valid_q | m_axi_tready;

    // Per-frame context restarts from zero on the IDLE beat that opens a frame.
    assign cur_idx   = (state_q == IDLE) ? 2'd0 : idx_q;
    assign cur_cnt   = (state_q == IDLE) ? '0 : cnt_q;
    assign cur_ovf   = (state_q == IDLE) ? 1'b0 : ovf_q;
    assign cnt_nx    = (cur_cnt == '1) ? cur_cnt : cur_cnt + LEN_W'(1);
    assign byte_done = (cur_idx == 2'd3) | s_axi_tlast;
    assign at_max    = (cnt_nx == LEN_W'(MAX_LEN + 1));
    assign end_err   = s_axi_tuser | (cur_idx != 2'd3) | (cnt_nx < LEN_W'(MIN_LEN)) |
                       (cnt_nx > LEN_W'(MAX_LEN)) | cur_ovf | crc_err;

    always_comb begin
        asm_byte = (cur_idx == 2'd0) ? 8'h00 : byte_q;
        asm_byte[{cur_idx, 1'b0} +: 2] = s_axi_tdata;
    end

`ifdef RMII_RX_FRAME_CTRL_CRC_CHECK_EN
    logic [31:0] crc_q, crc_cur, crc_nx, crc_rev;
    assign crc_cur = (state_q == IDLE) ? 32'hFFFFFFFF : crc_q;
    assign crc_nx  = crc32_update(crc_cur, asm_byte);
    // The register is LSB-first; the residue constant is quoted MSB-first.
    assign crc_rev = {<<{crc_nx}};
    assign crc_err = (crc_rev != CRC32_RESIDUE);

    always_ff @(posedge clock or negedge arstn) begin
        if (!arstn) begin
            crc_q <= 32'hFFFFFFFF;
        end else if (frame_beat && byte_done) begin
            crc_q <= crc_nx;
        end
    end
`else
    assign crc_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        byte_d      = byte_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        drop_d      = drop_q;
        term_d      = term_q;
        out_valid_d = out_valid_q & ~m_axi_tready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_user_d  = out_user_q;
        frame_beat  = 1'b0;
        drop_inc    = 1'b0;
        load        = 1'b0;
        load_data   = 8'h00;
        load_last   = 1'b0;
        load_user   = 1'b0;

        // Pending terminator only exists outside RECV, so it never competes with a data byte.
        if (term_q && out_free) begin
            load      = 1'b1;
            load_last = 1'b1;
            load_user = 1'b1;
            term_d    = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (s_beat) begin
                    if (enable && !term_q) begin
                        state_d    = RECV;
                        frame_beat = 1'b1;
                    end else if (s_axi_tlast) begin
                        drop_inc = 1'b1;
                    end else begin
                        state_d = DISCARD;
                        drop_d  = 1'b1;
                    end
                end
            end
            RECV:    frame_beat = s_beat;
            DISCARD: begin
                if (s_beat && s_axi_tlast) begin
                    state_d  = IDLE;
                    drop_inc = drop_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_beat) begin
            idx_d  = cur_idx + 2'd1;
            byte_d = asm_byte;
            cnt_d  = cur_cnt;
            ovf_d  = cur_ovf;
            if (byte_done) begin
                cnt_d = cnt_nx;
                if (s_axi_tlast || at_max) begin
                    state_d = s_axi_tlast ? IDLE : DISCARD;
                    drop_d  = 1'b0;
                    if (cur_ovf || !out_free) begin
                        term_d = 1'b1;
                    end else begin
                        load      = 1'b1;
                        load_data = asm_byte;
                        load_last = 1'b1;
                        load_user = s_axi_tlast ? end_err : 1'b1;
                    end
                end else if (!cur_ovf) begin
                    if (out_free) begin
                        load      = 1'b1;
                        load_data = asm_byte;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = load_data;
            out_last_d  = load_last;
            out_user_d  = load_user;
        end
    end

    always_ff @(posedge clock or negedge arstn) begin
        if (!arstn) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            byte_q      <= 8'h00;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
            term_q      <= 1'b0;
            s_tready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            byte_q      <= byte_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
            term_q      <= term_d;
            s_tready_q  <= 1'b1;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_user_q  <= out_user_d;
        end
    end

    assign s_axi_tready = s_tready_q;
    assign m_axi_tvalid = out_valid_q;
    assign m_axi_tdata  = out_data_q;
    assign m_axi_tlast  = out_last_q;
    assign m_axi_tuser  = out_user_q;
    assign busy         = (state_q == RECV) || (state_q == DISCARD);

    assign ok_inc  = out_valid_q & m_axi_tready & out_last_q & ~out_user_q;
    assign err_inc = out_valid_q & m_axi_tready & out_last_q & out_user_q;

    rmii_rx_sat_counter #(.CNT_W(CNT_W)) u_ok_cnt (
        .clk_i(clock), .rst_ni(arstn), .clr_i(cnt_clr), .inc_i(ok_inc), .cnt_o(frame_ok_cnt)
    );

    rmii_rx_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk_i(clock), .rst_ni(arstn), .clr_i(cnt_clr), .inc_i(err_inc), .cnt_o(frame_err_cnt)
    );

    rmii_rx_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk_i(clock), .rst_ni(arstn), .clr_i(cnt_clr), .inc_i(drop_inc), .cnt_o(frame_drop_cnt)
    );

endmodule

// File: tb/tb_rmii_rx_frame_ctrl.sv
// Directed bench for rmii_rx_frame_ctrl: reset, framing, length/alignment errors, backpressure,
// enable gating, oversize truncation and FCS handling (expectation follows RMII_RX_FRAME_CTRL_CRC_CHECK_EN).
module tb_rmii_rx_frame_ctrl;

    localparam int CNT_W = 16;
`ifdef RMII_RX_FRAME_CTRL_CRC_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             arstn = 1'b0;
    logic             enable = 1'b1;
    logic             cnt_clr = 1'b0;
    logic             s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
    logic [1:0]       s_tdata = 2'b00;
    logic             s_tready;
    logic             m_tvalid, m_tlast, m_tuser;
    logic [7:0]       m_tdata;
    logic             m_tready = 1'b1;
    logic             busy;
    logic [CNT_W-1:0] ok_cnt, err_cnt, drop_cnt;

    logic [7:0] frame_q[$];
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       busy_before_last, busy_after_last;

    rmii_rx_frame_ctrl #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(CNT_W)) dut (
        .clock(clock), .arstn(arstn), .enable(enable), .cnt_clr(cnt_clr),
        .s_axi_tvalid(s_tvalid), .s_axi_tlast(s_tlast), .s_axi_tdata(s_tdata),
        .s_axi_tuser(s_tuser), .s_axi_tready(s_tready),
        .m_axi_tvalid(m_tvalid), .m_axi_tlast(m_tlast), .m_axi_tdata(m_tdata),
        .m_axi_tuser(m_tuser), .m_axi_tready(m_tready), .busy(busy),
        .frame_ok_cnt(ok_cnt), .frame_err_cnt(err_cnt), .frame_drop_cnt(drop_cnt)
    );

    // clock / reset
    always #10 clock = ~clock;

    // output capture: one entry {tlast, tuser, tdata} per handshake
    always @(negedge clock) begin
        if (arstn && m_tvalid && m_tready) got_q.push_back({m_tlast, m_tuser, m_tdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // n bytes total: n-4 pattern bytes (first is 0xD5) followed by a valid little-endian FCS
    task automatic build_frame(input int n);
        logic [31:0] c;
        logic [7:0]  b;
        frame_q.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            b = (i == 0) ? 8'hD5 : 8'(i * 13 + 5);
            frame_q.push_back(b);
            c = crc_byte(c, b);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) frame_q.push_back(c[8*k +: 8]);
    endtask

    task automatic expect_bytes(input int n, input logic user);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), (i == n - 1) & user, frame_q[i]});
        end
    endtask

    // driver: one dibit per cycle, LSB dibit first; optional m_tready stall and enable rise
    task automatic send_frame(input int n_dibits, input logic err, input int stall_at,
                              input int stall_len, input int en_at);
        logic [7:0] b;
        for (int j = 0; j < n_dibits; j++) begin
            @(posedge clock);
            #1;
            b        = frame_q[j / 4];
            s_tvalid = 1'b1;
            s_tdata  = b[2*(j % 4) +: 2];
            s_tlast  = (j == n_dibits - 1);
            s_tuser  = err && (j == n_dibits - 1);
            m_tready = !((j >= stall_at) && (j < stall_at + stall_len));
            if (j == en_at) enable = 1'b1;
            if (j == n_dibits - 1) busy_before_last = busy;
        end
        @(posedge clock);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        m_tready = 1'b1;
        busy_after_last = busy;
    endtask

    // scoreboard drain and compare against exp_q
    task automatic compare_stream(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), {22'h0, got_q[i]}, {22'h0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_counters();
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        idle(1);
    endtask

    initial begin
        // reset values
        idle(3);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_ok_cnt", ok_cnt, 0);
        arstn = 1'b1;
        idle(3);
        check("post_rst_s_tready", s_tready, 1);
        check("post_rst_m_tdata", m_tdata, 0);
        check("post_rst_drop_cnt", drop_cnt, 0);

        // 1: legal 64-byte frame
        build_frame(64);
        expect_bytes(64, 1'b0);
        send_frame(256, 1'b0, -1, 0, -1);
        check("t1_busy_mid", busy_before_last, 1);
        check("t1_busy_end", busy_after_last, 0);
        idle(20);
        check("t1_first", {22'h0, got_q[0]}, {22'h0, 2'b00, 8'hD5});
        compare_stream("t1");
        check("t1_ok_cnt", ok_cnt, 1);
        check("t1_err_cnt", err_cnt, 0);

        // 2: runt frame, then a frame ending on a partial byte
        clear_counters();
        check("clr_ok_cnt", ok_cnt, 0);
        build_frame(60);
        expect_bytes(60, 1'b1);
        send_frame(240, 1'b0, -1, 0, -1);
        idle(20);
        compare_stream("t2a");
        check("t2a_err_cnt", err_cnt, 1);
        build_frame(64);
        frame_q.push_back(8'hF3);
        expect_bytes(64, 1'b0);
        exp_q[63] = {2'b00, frame_q[63]};
        exp_q.push_back({2'b11, 8'h03});
        send_frame(258, 1'b0, -1, 0, -1);
        idle(20);
        compare_stream("t2b");
        check("t2b_err_cnt", err_cnt, 2);
        check("t2b_ok_cnt", ok_cnt, 0);

        // 3: 10-cycle stall mid frame, bytes 0..9 delivered, then a lone terminator
        clear_counters();
        build_frame(100);
        for (int i = 0; i < 10; i++) exp_q.push_back({2'b00, frame_q[i]});
        exp_q.push_back({2'b11, 8'h00});
        send_frame(400, 1'b0, 40, 10, -1);
        idle(20);
        compare_stream("t3");
        check("t3_err_cnt", err_cnt, 1);
        check("t3_ok_cnt", ok_cnt, 0);

        // 4: disabled at frame start, enable raised mid frame; next frame normal
        clear_counters();
        enable = 1'b0;
        build_frame(64);
        send_frame(256, 1'b0, -1, 0, 100);
        idle(20);
        compare_stream("t4a");
        check("t4a_drop_cnt", drop_cnt, 1);
        expect_bytes(64, 1'b0);
        send_frame(256, 1'b0, -1, 0, -1);
        idle(20);
        compare_stream("t4b");
        check("t4b_ok_cnt", ok_cnt, 1);
        check("t4b_drop_cnt", drop_cnt, 1);

        // 5: oversize frame truncated at byte 1519
        clear_counters();
        build_frame(1600);
        expect_bytes(1519, 1'b1);
        send_frame(6400, 1'b0, -1, 0, -1);
        check("t5_busy_mid", busy_before_last, 1);
        check("t5_busy_end", busy_after_last, 0);
        idle(20);
        compare_stream("t5");
        check("t5_err_cnt", err_cnt, 1);
        check("t5_drop_cnt", drop_cnt, 0);

        // 6: good FCS, then one payload bit flipped
        clear_counters();
        build_frame(64);
        expect_bytes(64, 1'b0);
        send_frame(256, 1'b0, -1, 0, -1);
        idle(20);
        compare_stream("t6a");
        frame_q[10] = frame_q[10] ^ 8'h04;
        expect_bytes(64, CRC_ON);
        send_frame(256, 1'b0, -1, 0, -1);
        idle(20);
        compare_stream("t6b");
        check("t6_ok_cnt", ok_cnt, CRC_ON ? 1 : 2);

        // receiver error flag on an otherwise good frame
        clear_counters();
        build_frame(64);
        expect_bytes(64, 1'b1);
        send_frame(256, 1'b1, -1, 0, -1);
        idle(20);
        compare_stream("t7");
        check("t7_err_cnt", err_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rmii_rx_frame_ctrl.md
Name: rmii_rx_frame_ctrl

Overview:
Frame controller placed directly after the RMII MAC receiver. It accepts the receiver's 2-bit AXI stream and assembles dibits into bytes, LSB dibit first. It gates reception with a software enable, enforces frame length and alignment rules, and handles downstream backpressure without stalling the receiver. It delivers a byte-wide AXI stream with per-frame error marking and maintains statistics counters.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes (FCS included)
MAX_LEN, 1518, maximum legal frame length in bytes (FCS included)
CNT_W, 16, width of each statistics counter

Ports:
clock  in  1  system clock, 50 MHz
arstn  in  1  asynchronous reset, active low
enable  in  1  reception enable, sampled only at frame start
cnt_clr  in  1  synchronous clear of all statistics counters
s_axi_tvalid  in  1  dibit valid from MAC receiver
s_axi_tlast  in  1  last dibit of frame
s_axi_tdata  in  2  dibit
s_axi_tuser  in  1  receiver error flag, valid with tlast
s_axi_tready  out  1  always 1 after reset
m_axi_tvalid  out  1  byte valid
m_axi_tlast  out  1  last byte of frame
m_axi_tdata  out  8  byte
m_axi_tuser  out  1  frame error, meaningful only with tlast
m_axi_tready  in  1  downstream ready
busy  out  1  high in RECV or DISCARD
frame_ok_cnt  out  CNT_W  frames delivered with tuser=0
frame_err_cnt  out  CNT_W  frames delivered with tuser=1
frame_drop_cnt  out  CNT_W  frames discarded with no output

Behaviour:
Interface: one clock; reset is asynchronous and active-low (clock, arstn).
Reset values: all outputs 0, except s_axi_tready, which is 1 (also 0 while arstn is low). State is IDLE and all counters are 0. Reset asserted mid-frame aborts the frame silently; no terminator byte is sent.
s_axi_tready is never deasserted, because the receiver treats tready low as an error.
Byte assembly:
- dibit k of a byte (k = 0..3) is written to bits [2k+1:2k].
- dibits accepted on cycles n..n+3 appear on m_axi_* on cycle n+4 (registered, 1-entry output register).
- The output register holds its contents while m_axi_tvalid && !m_axi_tready.
States:
- IDLE: on the first s beat, go to RECV if enable=1 and no terminator is pending; otherwise go to DISCARD with drop_flag=1.
- RECV: assemble bytes and count them (11-bit counter, saturating).
  - A byte completes while the output register is occupied and not draining this cycle: that byte is lost, the overflow flag is set, and further bytes of the frame are suppressed.
  - Byte count reaches MAX_LEN+1: that byte is emitted with tlast=1, tuser=1, err_cnt increments, then go to DISCARD with drop_flag=0.
  - On an s beat with tlast, the frame error is the OR of: s_axi_tuser, a partial byte (dibit index != 3), byte count < MIN_LEN, overflow, and CRC failure (optional feature).
    - A partial byte is emitted zero-padded.
    - The final byte carries tlast=1 and tuser=error.
    - Then return to IDLE.
  - If overflow occurred, or the final byte cannot be loaded, term_pending is set instead. A 0x00 byte with tlast=1, tuser=1 is loaded as soon as the register is free.
- DISCARD: accept and ignore beats until tlast, then go to IDLE. drop_cnt increments if drop_flag=1.
- enable changes mid-frame take effect at the next frame only.
Counters:
- Increment on the handshake of the tlast byte, according to its tuser value; drop_cnt increments as above.
- Saturate at 2^CNT_W-1.
- cnt_clr has priority over a simultaneous increment.

Optional Feature:
RMII_RX_FRAME_CTRL_CRC_CHECK_EN
- Defined: an IEEE CRC-32 (reflected, init 0xFFFFFFFF) runs over all bytes of the frame. A residue != 0xC704DD7B at tlast sets the frame error.
- Undefined: no CRC logic; CRC never contributes to the error.

Decomposition:
Package rmii_rx_frame_ctrl_pkg holds:
- the state enum (IDLE, RECV, DISCARD)
- CRC32_POLY 0xEDB88320 and CRC32_RESIDUE 0xC704DD7B
- a byte-wise CRC update function
- LEN_W = 11

One sub-module: rmii_rx_sat_counter (CNT_W, inc, clr), instantiated three times.

Test Plan:
1. enable=1, m_tready=1, 64-byte frame with first four dibits 01,01,01,11 -> first byte 0xD5, 64 bytes out, last has tlast=1 tuser=0, ok_cnt=1.
2. 60-byte frame -> 60 bytes out, last tuser=1, err_cnt=1; then a 258-dibit frame -> 65th byte = zero-padded partial (upper nibble 0), tlast=1 tuser=1, err_cnt=2.
3. m_tready=0 for 10 cycles mid 100-byte frame -> held byte is delivered, later bytes suppressed, single 0x00 tlast tuser=1 emitted after tready returns, err_cnt=1.
4. enable=0 at frame start, raised mid-frame -> no m output, drop_cnt=1; the following frame is delivered normally.
5. 1600-byte frame -> byte 1519 has tlast=1 tuser=1, no further output, err_cnt=1, busy stays high until s tlast.
6. With CRC_CHECK_EN: 64-byte frame with correct FCS -> tuser=0; same frame with one bit flipped -> tuser=1. Without the macro, both give tuser=0.
